// File: rtl/citadel_pkg.sv
// Shared register map, bit positions and helpers for the citadel_io MMIO block.
// Offsets are relative to BASE_ADDR; channel registers repeat every 0x10 from 0x10.
package citadel_pkg;

    localparam logic [7:0]  PANIC_MAGIC_DEFAULT = 8'h42;

    localparam logic [15:0] OFF_PANIC   = 16'h0000;
    localparam logic [15:0] OFF_GSTAT   = 16'h0004;
    localparam logic [3:0]  OFF_DATA    = 4'h0;
    localparam logic [3:0]  OFF_STAT    = 4'h4;
    localparam logic [3:0]  OFF_CTRL    = 4'h8;

    localparam int unsigned STAT_RX_NONEMPTY = 32'd0;
    localparam int unsigned STAT_TX_FULL     = 32'd1;
    localparam int unsigned STAT_TX_EMPTY    = 32'd2;
    localparam int unsigned STAT_RX_OVF      = 32'd3;
    localparam int unsigned STAT_TX_OVF      = 32'd4;
    localparam int unsigned STAT_RX_CNT_LSB  = 32'd8;
    localparam int unsigned STAT_TX_CNT_LSB  = 32'd16;

    localparam int unsigned GSTAT_RECOVERY   = 32'd0;
    localparam int unsigned GSTAT_UNMAPPED   = 32'd1;

    localparam int unsigned CTRL_RX_EN       = 32'd0;
    localparam int unsigned CTRL_TX_EN       = 32'd1;
    localparam int unsigned CTRL_RX_FLUSH    = 32'd2;
    localparam int unsigned CTRL_TX_FLUSH    = 32'd3;

    typedef enum logic [2:0] {
        REG_PANIC    = 3'd0,
        REG_GSTAT    = 3'd1,
        REG_DATA     = 3'd2,
        REG_STAT     = 3'd3,
        REG_CTRL     = 3'd4,
        REG_UNMAPPED = 3'd5
    } reg_sel_e;

    // Counts of a 256-deep FIFO need 9 bits; the STAT field saturates.
    function automatic logic [7:0] cnt8(input logic [8:0] n);
        return (n > 9'd255) ? 8'hFF : n[7:0];
    endfunction

    function automatic logic [31:0] stat_pack(input logic rx_ne, input logic tx_full,
                                              input logic tx_empty, input logic rx_ovf,
                                              input logic tx_ovf, input logic [8:0] rx_cnt,
                                              input logic [8:0] tx_cnt);
        logic [31:0] w;
        w = 32'd0;
        w[STAT_RX_NONEMPTY]         = rx_ne;
        w[STAT_TX_FULL]             = tx_full;
        w[STAT_TX_EMPTY]            = tx_empty;
        w[STAT_RX_OVF]              = rx_ovf;
        w[STAT_TX_OVF]              = tx_ovf;
        w[STAT_RX_CNT_LSB +: 8]     = cnt8(rx_cnt);
        w[STAT_TX_CNT_LSB +: 8]     = cnt8(tx_cnt);
        return w;
    endfunction

endpackage

// File: rtl/citadel_fifo.sv
// Power-of-two synchronous FIFO with flush. Flush beats push/pop; a push into a
// full FIFO is only taken when a pop happens in the same cycle.
module citadel_fifo #(
    parameter int WIDTH = 32'd8,
    parameter int DEPTH = 32'd8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s, pop_s;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Effective push/pop after flush priority and full/empty qualification.
    always_comb begin
        pop_s   = pop && !empty && !flush;
        push_s  = push && !flush && (!full || pop_s);
        count_d = count_q;
        if (flush) begin
            count_d = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= {AW{1'b0}};
                rd_ptr_q <= {AW{1'b0}};
            end else begin
                if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/citadel_io.sv
// Memory-mapped byte-channel I/O block with per-channel RX/TX FIFOs and a sticky
// panic latch that silences the channels but keeps the bus responding.
module citadel_io
    import citadel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
    parameter int          N_CH        = 32'd2,
    parameter int          FIFO_DEPTH  = 32'd8,
    parameter logic [7:0]  PANIC_MAGIC = PANIC_MAGIC_DEFAULT
) (
    input  logic                r_clk,
    input  logic                rst_n,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [3:0]          mem_wstrb,
    output logic [31:0]         mem_rdata,
    output logic [8*N_CH-1:0]   tx_data,
    output logic [N_CH-1:0]     tx_valid,
    input  logic [N_CH-1:0]     tx_ready,
    input  logic [8*N_CH-1:0]   rx_data,
    input  logic [N_CH-1:0]     rx_valid,
    output logic [N_CH-1:0]     rx_ack,
    output logic                panic,
    input  logic                recovery
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [11:0] N_CH_W = 12'(N_CH);

    logic            mem_ready_q, panic_q, unm_q;
    logic [31:0]     mem_rdata_q, rdata_d;
    logic [N_CH-1:0] rx_ack_q, rx_en_q, tx_en_q, rx_ovf_q, tx_ovf_q;
    logic [N_CH-1:0] rx_en_d, tx_en_d, rx_ovf_d, tx_ovf_d;

    logic            hit_s, accept_s, wr_s, ch_ok_s;
    logic            panic_set_s, unm_set_s, unm_clr_s;
    logic [11:0]     chn_s;
    reg_sel_e        reg_s;
    logic [N_CH-1:0] sel_s, rx_acc_s, rx_pop_s, rx_flush_s, tx_push_s, tx_pop_s, tx_flush_s;
    logic [N_CH-1:0] tx_valid_s;

    logic            rx_full_s [N_CH];
    logic            rx_empty_s [N_CH];
    logic            tx_full_s [N_CH];
    logic            tx_empty_s [N_CH];
    logic [7:0]      rx_head_s [N_CH];
    logic [7:0]      tx_head_s [N_CH];
    logic [CW-1:0]   rx_cnt_s [N_CH];
    logic [CW-1:0]   tx_cnt_s [N_CH];
    logic            unused_s;

    assign unused_s = ^{mem_wdata[31:8], BASE_ADDR[15:0]};

    // A request is taken only on a cycle where no response is being presented.
    assign hit_s    = (mem_addr[31:16] == BASE_ADDR[31:16]);
    assign accept_s = mem_valid && !mem_ready_q && hit_s;
    assign wr_s     = (mem_wstrb != 4'b0000);
    assign chn_s    = mem_addr[15:4] - 12'd1;
    assign ch_ok_s  = (mem_addr[15:4] != 12'd0) && (chn_s < N_CH_W);

    // Register select within the window.
    always_comb begin
        reg_s = REG_UNMAPPED;
        if (mem_addr[15:0] == OFF_PANIC) begin
            reg_s = REG_PANIC;
        end else if (mem_addr[15:0] == OFF_GSTAT) begin
            reg_s = REG_GSTAT;
        end else if (ch_ok_s) begin
            case (mem_addr[3:0])
                OFF_DATA: reg_s = REG_DATA;
                OFF_STAT: reg_s = REG_STAT;
                OFF_CTRL: reg_s = REG_CTRL;
                default:  reg_s = REG_UNMAPPED;
            endcase
        end else begin
            reg_s = REG_UNMAPPED;
        end
    end

    // Bus side effects, read mux and per-channel flow control.
    always_comb begin
        rdata_d     = 32'd0;
        panic_set_s = 1'b0;
        unm_set_s   = 1'b0;
        unm_clr_s   = 1'b0;
        sel_s       = '0;
        rx_acc_s    = '0;
        rx_pop_s    = '0;
        rx_flush_s  = '0;
        tx_push_s   = '0;
        tx_pop_s    = '0;
        tx_flush_s  = '0;
        tx_valid_s  = '0;
        rx_en_d     = rx_en_q;
        tx_en_d     = tx_en_q;
        rx_ovf_d    = rx_ovf_q;
        tx_ovf_d    = tx_ovf_q;
        if (accept_s) begin
            case (reg_s)
                REG_PANIC: begin
                    rdata_d     = {31'd0, panic_q};
                    panic_set_s = wr_s && mem_wstrb[0] && (mem_wdata[7:0] == PANIC_MAGIC);
                end
                REG_GSTAT: begin
                    rdata_d   = {30'd0, unm_q, recovery};
                    unm_clr_s = wr_s && mem_wstrb[0] && mem_wdata[GSTAT_UNMAPPED];
                end
                REG_UNMAPPED: unm_set_s = 1'b1;
                default: ;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
        for (int c = 32'd0; c < N_CH; c++) begin
            sel_s[c]      = accept_s && ch_ok_s && (chn_s == 12'(c));
            tx_valid_s[c] = !tx_empty_s[c] && tx_en_q[c] && !panic_q;
            tx_pop_s[c]   = tx_valid_s[c] && tx_ready[c];
            rx_acc_s[c]   = rx_valid[c] && !rx_ack_q[c] && rx_en_q[c] && !panic_q;
            if (sel_s[c]) begin
                case (reg_s)
                    REG_DATA: begin
                        if (wr_s) begin
                            tx_push_s[c] = mem_wstrb[0];
                        end else begin
                            rx_pop_s[c] = !rx_empty_s[c];
                            rdata_d     = rx_empty_s[c] ? 32'd0 : {23'd0, 1'b1, rx_head_s[c]};
                        end
                    end
                    REG_STAT: begin
                        if (!wr_s) begin
                            rdata_d = stat_pack(!rx_empty_s[c], tx_full_s[c], tx_empty_s[c],
                                                rx_ovf_q[c], tx_ovf_q[c],
                                                9'(rx_cnt_s[c]), 9'(tx_cnt_s[c]));
                        end else if (mem_wstrb[0]) begin
                            rx_ovf_d[c] = rx_ovf_q[c] && !mem_wdata[STAT_RX_OVF];
                            tx_ovf_d[c] = tx_ovf_q[c] && !mem_wdata[STAT_TX_OVF];
                        end else begin
                            rdata_d = 32'd0;
                        end
                    end
                    REG_CTRL: begin
                        if (!wr_s) begin
                            rdata_d = {30'd0, tx_en_q[c], rx_en_q[c]};
                        end else if (mem_wstrb[0]) begin
                            rx_en_d[c]    = mem_wdata[CTRL_RX_EN];
                            tx_en_d[c]    = mem_wdata[CTRL_TX_EN];
                            rx_flush_s[c] = mem_wdata[CTRL_RX_FLUSH];
                            tx_flush_s[c] = mem_wdata[CTRL_TX_FLUSH];
                        end else begin
                            rdata_d = 32'd0;
                        end
                    end
                    default: ;
                endcase
            end
            // Overflow set is evaluated after the W1C so a same-cycle event is not lost.
            if (rx_acc_s[c] && rx_full_s[c] && !rx_pop_s[c] && !rx_flush_s[c]) rx_ovf_d[c] = 1'b1;
            if (tx_push_s[c] && tx_full_s[c] && !tx_pop_s[c] && !tx_flush_s[c]) tx_ovf_d[c] = 1'b1;
        end
    end

    // Bus response, sticky flags and channel control state.
    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'd0;
            panic_q     <= 1'b0;
            unm_q       <= 1'b0;
            rx_ack_q    <= '0;
            rx_en_q     <= '1;
            tx_en_q     <= '1;
            rx_ovf_q    <= '0;
            tx_ovf_q    <= '0;
        end else begin
            mem_ready_q <= accept_s;
            mem_rdata_q <= (accept_s && !wr_s) ? rdata_d : 32'd0;
            panic_q     <= panic_q || panic_set_s;
            unm_q       <= unm_set_s || (unm_q && !unm_clr_s);
            rx_ack_q    <= rx_acc_s;
            rx_en_q     <= rx_en_d;
            tx_en_q     <= tx_en_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        citadel_fifo #(.WIDTH(32'd8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
            .clk   (r_clk),
            .rst_n (rst_n),
            .push  (rx_acc_s[g]),
            .pop   (rx_pop_s[g]),
            .flush (rx_flush_s[g]),
            .wdata (rx_data[g*8 +: 8]),
            .rdata (rx_head_s[g]),
            .full  (rx_full_s[g]),
            .empty (rx_empty_s[g]),
            .count (rx_cnt_s[g])
        );
        citadel_fifo #(.WIDTH(32'd8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
            .clk   (r_clk),
            .rst_n (rst_n),
            .push  (tx_push_s[g]),
            .pop   (tx_pop_s[g]),
            .flush (tx_flush_s[g]),
            .wdata (mem_wdata[7:0]),
            .rdata (tx_head_s[g]),
            .full  (tx_full_s[g]),
            .empty (tx_empty_s[g]),
            .count (tx_cnt_s[g])
        );
        assign tx_data[g*8 +: 8] = tx_empty_s[g] ? 8'h00 : tx_head_s[g];
    end

    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign tx_valid  = tx_valid_s;
    assign rx_ack    = rx_ack_q;
    assign panic     = panic_q;

endmodule

// File: tb/tb_citadel_io.sv
// Directed bench for citadel_io: bus responses are checked by a scoreboard monitor,
// channel pins are checked inline against hand-computed values.
module tb_citadel_io;

    localparam int N_CH = 2;
    localparam logic [31:0] B = 32'h0100_0000;
    localparam logic [31:0] A_PANIC = B + 32'h0, A_GSTAT = B + 32'h4;
    localparam logic [31:0] A_D0 = B + 32'h10, A_S0 = B + 32'h14, A_C0 = B + 32'h18;
    localparam logic [31:0] A_D1 = B + 32'h20, A_S1 = B + 32'h24, A_C1 = B + 32'h28;

    logic              r_clk = 1'b0, rst_n = 1'b0;
    logic              mem_valid = 1'b0, mem_ready;
    logic [31:0]       mem_addr = 32'd0, mem_wdata = 32'd0, mem_rdata;
    logic [3:0]        mem_wstrb = 4'd0;
    logic [8*N_CH-1:0] tx_data, rx_data = '0;
    logic [N_CH-1:0]   tx_valid, tx_ready = '0, rx_valid = '0, rx_ack;
    logic              panic, recovery = 1'b1;

    int total = 0, bad = 0, acks = 0;

    typedef struct { string nm; logic [31:0] exp; logic chk; } sb_t;
    sb_t sb_q[$];

    citadel_io #(.BASE_ADDR(B), .N_CH(N_CH), .FIFO_DEPTH(8), .PANIC_MAGIC(8'h42)) dut (
        .r_clk(r_clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .panic(panic), .recovery(recovery)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: every mem_ready must match a queued request.
    logic prev_ready = 1'b0;
    sb_t  e;
    always @(posedge r_clk) begin
        #1;
        if (mem_ready) begin
            chk("ready_gap", {31'd0, prev_ready}, 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.chk) chk(e.nm, mem_rdata, e.exp);
            end
        end
        prev_ready = mem_ready;
    end

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] exp, input string nm, input logic [N_CH-1:0] txr);
        @(negedge r_clk);
        mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_valid = 1'b1; tx_ready = txr;
        sb_q.push_back('{nm, exp, (ws == 4'd0)});
        @(posedge r_clk); #1;
        chk({nm, "_lat"}, {31'd0, mem_ready}, 32'd1);
        @(negedge r_clk);
        mem_valid = 1'b0; tx_ready = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus(a, 32'd0, 4'd0, exp, nm, '0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
        bus(a, d, 4'hF, 32'd0, nm, '0);
    endtask

    task automatic rx_send(input int ch, input logic [7:0] b);
        logic got;
        @(negedge r_clk);
        rx_data[ch*8 +: 8] = b; rx_valid[ch] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge r_clk); #1;
            if (rx_ack[ch]) got = 1'b1;
        end
        chk("rx_ack_seen", {31'd0, got}, 32'd1);
        if (got) acks++;
        @(negedge r_clk);
        rx_valid[ch] = 1'b0;
        @(posedge r_clk); #1;
        chk("rx_ack_pulse", {31'd0, rx_ack[ch]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge r_clk);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_txv", {30'd0, tx_valid}, 32'd0);
        chk("rst_txd", {16'd0, tx_data}, 32'd0);
        chk("rst_panic", {31'd0, panic}, 32'd0);
        rst_n = 1'b1;

        rd(A_GSTAT, 32'h1, "gstat_init");
        rd(A_C0, 32'h3, "ctrl_init");
        rd(A_S0, 32'h4, "stat_init");

        // Single TX byte and one pop.
        wr(A_D0, 32'h41, "wr_41");
        chk("txv_41", {30'd0, tx_valid}, 32'h1);
        chk("txd_41", {24'd0, tx_data[7:0]}, 32'h41);
        rd(A_S0, 32'h0001_0000, "stat_one");
        tx_ready = 2'b01;
        @(posedge r_clk); #1;
        chk("txv_after_pop", {30'd0, tx_valid}, 32'h0);
        @(negedge r_clk); tx_ready = '0;
        rd(A_S0, 32'h4, "stat_drained");

        // Fill TX, then push into full with a same-cycle pop, then overflow.
        for (int i = 0; i < 8; i++) wr(A_D0, 32'hA0 + i, "fill");
        rd(A_S0, 32'h0008_0002, "stat_full");
        bus(A_D0, 32'hA8, 4'hF, 32'd0, "wr_full_pop", 2'b01);
        rd(A_S0, 32'h0008_0002, "stat_full_pop");
        chk("txd_head", {24'd0, tx_data[7:0]}, 32'hA1);
        wr(A_D0, 32'hFF, "wr_ovf");
        rd(A_S0, 32'h0008_0012, "stat_txovf");
        wr(A_S0, 32'h10, "w1c_txovf");
        rd(A_S0, 32'h0008_0002, "stat_txovf_clr");
        tx_ready = 2'b01;
        for (int i = 0; i < 8; i++) begin
            chk("drain_v", {31'd0, tx_valid[0]}, 32'd1);
            chk("drain_d", {24'd0, tx_data[7:0]}, 32'hA1 + i);
            @(posedge r_clk); @(negedge r_clk);
        end
        tx_ready = '0;
        chk("drain_end", {31'd0, tx_valid[0]}, 32'd0);

        // tx_en gating and TX flush.
        wr(A_C0, 32'h1, "ctrl_txoff");
        wr(A_D0, 32'h33, "wr_33");
        chk("txv_disabled", {30'd0, tx_valid}, 32'h0);
        wr(A_C0, 32'hB, "ctrl_txflush");
        rd(A_S0, 32'h4, "stat_flushed");
        rd(A_C0, 32'h3, "ctrl_after_flush");

        // Nine RX bytes into an 8-deep FIFO.
        for (int i = 1; i <= 9; i++) rx_send(1, 8'(i));
        chk("rx_ack_count", acks, 32'd9);
        rd(A_S1, 32'h0000_080D, "stat_rxovf");
        for (int i = 1; i <= 8; i++) rd(A_D1, 32'h100 + i, "rx_data");
        rd(A_D1, 32'h0, "rx_empty_read");
        rd(A_S1, 32'hC, "stat_rx_drained");
        wr(A_S1, 32'h8, "w1c_rxovf");
        rd(A_S1, 32'h4, "stat_rxovf_clr");
        rx_send(1, 8'h5A);
        wr(A_C1, 32'h7, "ctrl_rxflush");
        rd(A_S1, 32'h4, "stat_rxflushed");

        // Unmapped accesses inside the window, and an unclaimed one outside it.
        rd(B + 32'h200, 32'h0, "unmapped_rd");
        rd(A_GSTAT, 32'h3, "gstat_unm");
        wr(A_GSTAT, 32'h2, "gstat_clr");
        rd(A_GSTAT, 32'h1, "gstat_cleared");
        rd(B + 32'h30, 32'h0, "ch2_rd");
        wr(A_GSTAT, 32'h2, "gstat_clr2");
        @(negedge r_clk);
        mem_addr = 32'h0200_0000; mem_wstrb = 4'd0; mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge r_clk); #1;
            chk("outside_noresp", {31'd0, mem_ready}, 32'd0);
        end
        @(negedge r_clk); mem_valid = 1'b0;

        // Panic: wrong magic ignored, magic latches and silences channels.
        wr(A_D0, 32'h55, "wr_55");
        chk("txv_pre_panic", {30'd0, tx_valid}, 32'h1);
        wr(A_PANIC, 32'h41, "panic_wrong");
        chk("panic_wrong", {31'd0, panic}, 32'd0);
        wr(A_PANIC, 32'h42, "panic_magic");
        chk("panic_set", {31'd0, panic}, 32'd1);
        chk("txv_panic", {30'd0, tx_valid}, 32'h0);
        rx_valid[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge r_clk); #1;
            chk("rx_ack_panic", {30'd0, rx_ack}, 32'h0);
        end
        @(negedge r_clk); rx_valid = '0;
        rd(A_PANIC, 32'h1, "panic_rd");
        rd(A_GSTAT, 32'h1, "gstat_panic");

        // Reset while a request is pending.
        @(negedge r_clk);
        mem_addr = A_D0; mem_wdata = 32'h99; mem_wstrb = 4'hF; mem_valid = 1'b1;
        #3 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge r_clk); #1;
            chk("rst_abort", {31'd0, mem_ready}, 32'd0);
        end
        @(negedge r_clk); mem_valid = 1'b0;
        chk("rst2_panic", {31'd0, panic}, 32'd0);
        chk("rst2_txv", {30'd0, tx_valid}, 32'h0);
        chk("rst2_txd", {16'd0, tx_data}, 32'h0);
        chk("rst2_rdata", mem_rdata, 32'h0);
        @(negedge r_clk); rst_n = 1'b1;
        wr(A_D0, 32'h77, "wr_after_rst");
        chk("txv_after_rst", {30'd0, tx_valid}, 32'h1);
        chk("txd_after_rst", {24'd0, tx_data[7:0]}, 32'h77);
        rd(A_S0, 32'h0001_0000, "stat_after_rst");
        rd(A_C0, 32'h3, "ctrl_after_rst");

        repeat (2) @(negedge r_clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/citadel_io.md
CITADEL_IO -- requirements
Module: citadel_io

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0100_0000, base of the MMIO window (64 KiB aligned).
REQ-002 SHALL have parameter N_CH, default 2, number of byte channels (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, per-direction FIFO depth (power of 2, 2..256).
REQ-004 SHALL have parameter PANIC_MAGIC, default 8'h42, byte that triggers panic.
REQ-005 SHALL have port r_clk, input, 1: sole clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port mem_valid, input, 1: CPU request valid.
REQ-008 SHALL have port mem_ready, output, 1: one-cycle response strobe.
REQ-009 SHALL have ports mem_addr (input, 32), mem_wdata (input, 32) and mem_wstrb (input, 4): address, write data and byte strobes; wstrb==0 means read.
REQ-010 SHALL have port mem_rdata, output, 32: read data, valid while mem_ready is high.
REQ-011 SHALL have ports tx_data (output, 8*N_CH) and tx_valid (output, N_CH): per-channel outbound byte, and held-valid flag.
REQ-012 SHALL have port tx_ready, input, N_CH: sink accepts the outbound byte.
REQ-013 SHALL have ports rx_data (input, 8*N_CH) and rx_valid (input, N_CH): per-channel inbound byte, and source presenting flag.
REQ-014 SHALL have port rx_ack, output, N_CH: one-cycle accept pulse.
REQ-015 SHALL have ports panic (output, 1: sticky panic flag) and recovery (input, 1: recovery strap, readable only).

Function
REQ-016 SHALL decode mem_addr within BASE+0x0000..0xFFFF; any other address is not claimed (mem_ready stays low).
REQ-017 SHALL assert mem_ready exactly one cycle after sampling mem_valid=1 with mem_ready=0, for one cycle only, then low for at least one cycle.
REQ-018 Register map SHALL be: BASE+0 PANIC; BASE+4 GSTAT; BASE+0x10+0x10*ch DATA, +4 STAT, +8 CTRL.
REQ-019 PANIC write with wdata[7:0]==PANIC_MAGIC and wstrb[0]=1 SHALL set panic; other writes are ignored; reads return {31'b0,panic}.
REQ-020 GSTAT read SHALL return bit0 recovery, bit1 unmapped-access sticky, others 0; writing 1 to bit1 SHALL clear it.
REQ-021 An access inside the window to an unlisted offset or channel >= N_CH SHALL read 0, drop writes, set the GSTAT bit1 sticky and still complete.
REQ-022 DATA read SHALL pop the RX FIFO and return {23'b0,1'b1,byte}; when empty it SHALL return 0 with no pop.
REQ-023 DATA write SHALL push wdata[7:0] to the TX FIFO when not full; when full the byte SHALL be dropped and STAT bit4 set.
REQ-024 STAT SHALL read bit0 rx_nonempty, bit1 tx_full, bit2 tx_empty, bit3 rx_overflow, bit4 tx_overflow, [15:8] rx count, [23:16] tx count; bits 3/4 are write-1-to-clear.
REQ-025 CTRL SHALL hold bit0 rx_en and bit1 tx_en (both reset 1); bit2 rx_flush and bit3 tx_flush SHALL be self-clearing, emptying the FIFO in the write cycle and reading 0.
REQ-026 tx_valid[ch] SHALL equal TX nonempty AND tx_en AND NOT panic; tx_data SHALL show the FIFO head; pop on tx_valid&&tx_ready.
REQ-027 When rx_valid[ch]=1, rx_ack[ch]=0, rx_en=1 and panic=0, the block SHALL pulse rx_ack[ch] for one cycle and push rx_data; if full, the byte SHALL be dropped and rx_overflow set.
REQ-028 Simultaneous push and pop on one FIFO SHALL both occur, including when full; overflow is not set, count unchanged.
REQ-029 Flush and push in the same cycle: flush SHALL win, the push is discarded with no overflow.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
REQ-031 Panic SHALL be sticky until reset and SHALL NOT stop bus responses.

Reset
REQ-032 On rst_n=0 SHALL immediately clear mem_ready, mem_rdata, tx_valid, rx_ack, panic, all stickies, FIFO pointers/counts, and set rx_en=tx_en=1; tx_data SHALL read 0.
REQ-033 Reset mid-transaction SHALL abort it with no response; the first request after release completes normally.

Structure
REQ-034 Register offsets, STAT/GSTAT/CTRL bit positions and the PANIC_MAGIC default SHALL live in shared package citadel_pkg.
REQ-035 The FIFO SHALL be sub-module citadel_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, count), instantiated 2*N_CH times.

Verification
REQ-036 Write 8'h41 to ch0 DATA, tx_ready=1 -> tx_valid[0] high with tx_data=8'h41 and a single pop; STAT[2]=1 afterwards.
REQ-037 Drive 9 rx bytes 0x01..0x09 on ch1 with FIFO_DEPTH=8 -> 9 rx_ack pulses; STAT bit3=1; DATA reads return 0x101..0x108, then 0.
REQ-038 Write 0x42 to PANIC -> panic=1, tx_valid all 0, rx_ack held 0; read PANIC=1; GSTAT still readable.
REQ-039 With TX full, write DATA while tx_ready pops in the same cycle -> byte accepted, tx count stays 8, bit4=0.
REQ-040 Read BASE+0x200 -> rdata 0, mem_ready after 1 cycle, GSTAT bit1=1; write 2 to GSTAT -> bit1=0.
REQ-041 Assert rst_n=0 one cycle after mem_valid -> no mem_ready; after release a DATA write completes in 1 cycle.
